tick_scheduler: RTL
===================

Name: tick_scheduler

Overview:
Multi-channel timer scheduler driven by the shared 1 kHz base tick from the tick generator. Software/FSM-side logic configures each channel with a period in base ticks and a mode (periodic or one-shot). The block counts base ticks per channel and raises one-cycle expiry pulses. It also arbitrates pending expiries onto a single valid/ack event port, lowest channel index first. It sits between the tick generator and the debounce, blink and timeout consumers.

Parameters:
NUM_CH, 4, number of timer channels; 1..2**CH_W.
CH_W, 2, width of the channel index.
CNT_WIDTH, 16, width of period and remaining-count registers.

Ports:
clk_100Mhz  input  1  system clock, 100 MHz.
rst  input  1  asynchronous, active-low reset; 0 = reset.
tick  input  1  base tick, one clk_100Mhz cycle wide.
cfg_we  input  1  configuration write strobe, one cycle.
cfg_ch  input  CH_W  target channel of the write.
cfg_en  input  1  1 = start/restart channel, 0 = stop channel.
cfg_mode  input  1  0 = periodic, 1 = one-shot.
cfg_period  input  CNT_WIDTH  period in base ticks; must be ≥1.
cfg_ack  output  1  one-cycle pulse, cycle after an accepted write.
cfg_err  output  1  one-cycle pulse, cycle after a rejected write.
ch_busy  output  NUM_CH  channel is in RUN.
ch_expire  output  NUM_CH  one-cycle expiry pulse per channel.
evt_valid  output  1  at least one expiry pending.
evt_ch  output  CH_W  lowest-index pending channel; valid only when evt_valid=1.
evt_ack  input  1  consumer acknowledge of evt_ch.
evt_ovr  output  NUM_CH  sticky flag: expiry occurred while that channel was already pending.

Behaviour:
- Reset (rst=0, asynchronous) clears all channels to IDLE.
  - Clears period, remaining and mode registers.
  - All outputs go to 0, including evt_ovr.
  - Effective immediately, including mid-count; on release, no channel runs until written.
- Per-channel FSM: IDLE, RUN.
  - IDLE → RUN: accepted write with cfg_en=1.
  - RUN → IDLE: accepted write with cfg_en=0, or a one-shot expiry.
- Write acceptance:
  - A write is rejected when cfg_ch ≥ NUM_CH, or when cfg_en=1 with cfg_period=0.
  - A rejected write changes no state and pulses cfg_err.
  - Otherwise the write is accepted and pulses cfg_ack.
  - Exactly one of cfg_ack/cfg_err pulses per cfg_we, in the following cycle.
- Accepted write with cfg_en=1:
  - period ← cfg_period, remaining ← cfg_period, mode ← cfg_mode, ch_busy=1 from the next cycle.
  - Rewriting a channel in RUN restarts it; the old count is discarded.
- Accepted write with cfg_en=0: channel goes to IDLE, ch_busy=0 next cycle, no expiry produced.
- Tick processing: on a cycle with tick=1, every RUN channel not being written that cycle does the following.
  - remaining > 1: decrement.
  - remaining == 1:
    - ch_expire[i]=1 for exactly the next cycle, and pending[i] is set.
    - Periodic: remaining ← period.
    - One-shot: go to IDLE, ch_busy=0 next cycle.
- Timing:
  - First expiry comes on the cfg_period-th tick after the write cycle.
  - A tick in the same cycle as the write is not counted.
  - Expiry latency is 1 cycle after the qualifying tick.
- Simultaneous tick and write to the same channel: the write wins; that tick is ignored for that channel only.
- Event arbiter:
  - evt_valid = OR(pending); evt_ch = lowest index with pending set.
  - Both are registered: they update the cycle after pending changes.
  - Handshake: evt_ack=1 while evt_valid=1 clears pending[evt_ch] at that edge. evt_ack with evt_valid=0 is ignored.
  - The consumer must not rely on evt_ch holding after an ack; the next pending channel appears the following cycle.
- Set and clear of the same pending bit in one cycle: set wins, so the bit stays pending, and evt_ovr[i] is set.
- A new expiry while pending[i] is already set also sets evt_ovr[i]. evt_ovr clears only on reset.
- Stopping a channel does not clear its pending bit.
- Counters never wrap: remaining ranges 1..period; CNT_WIDTH arithmetic is unsigned.

Test Plan:
- Reset, then write ch0 periodic period=3 and apply 7 ticks → ch_expire[0] pulses after ticks 3 and 6, ch_busy[0]=1 throughout, evt_valid=1 with evt_ch=0 after tick 3.
- ch1 one-shot period=2, 3 ticks → a single ch_expire[1] after tick 2, ch_busy[1]=0 the next cycle, no further expiry.
- Write ch2 with period=0 → cfg_err pulse, no cfg_ack, ch_busy[2]=0. With NUM_CH=3, a write to cfg_ch=3 → cfg_err.
- ch0 and ch3 expire on the same tick with no ack → evt_ch=0 first; ack → evt_ch=3 next cycle; ack → evt_valid=0.
- ch0 period=1, never acked, 2 ticks → evt_ovr[0]=1 stays set. Same-cycle tick and restart write on ch0 with period=5 → no expiry until the 5th subsequent tick.
- Assert rst=0 mid-count on ch1 with remaining=2 → all outputs 0 immediately. After release, 3 ticks produce no expiry.

Source files
------------

// File: rtl/tick_scheduler_if.sv
// Configuration-write and expiry-event handshake bundle for tick_scheduler.
// The master side issues channel writes and acknowledges events; the slave is the scheduler.
interface tick_scheduler_if #(
  parameter int unsigned CH_W      = 2,
  parameter int unsigned CNT_WIDTH = 16
);
  logic                 cfg_we;
  logic [CH_W-1:0]      cfg_ch;
  logic                 cfg_en;
  logic                 cfg_mode;
  logic [CNT_WIDTH-1:0] cfg_period;
  logic                 cfg_ack;
  logic                 cfg_err;
  logic                 evt_valid;
  logic [CH_W-1:0]      evt_ch;
  logic                 evt_ack;

  modport master (
    output cfg_we, cfg_ch, cfg_en, cfg_mode, cfg_period, evt_ack,
    input  cfg_ack, cfg_err, evt_valid, evt_ch
  );

  modport slave (
    input  cfg_we, cfg_ch, cfg_en, cfg_mode, cfg_period, evt_ack,
    output cfg_ack, cfg_err, evt_valid, evt_ch
  );
endinterface

// File: rtl/tick_scheduler.sv
// Multi-channel base-tick timer with periodic/one-shot modes and a lowest-index-first
// expiry event port with sticky overrun flags.
module tick_scheduler #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = 2,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic              clk_100Mhz,
  input  logic              rst,
  input  logic              tick,
  tick_scheduler_if.slave   bus,
  output logic [NUM_CH-1:0] ch_busy,
  output logic [NUM_CH-1:0] ch_expire,
  output logic [NUM_CH-1:0] evt_ovr
);

  typedef enum logic {StIdle, StRun} ch_state_e;

  ch_state_e            state_q  [NUM_CH];
  ch_state_e            state_d  [NUM_CH];
  logic [CNT_WIDTH-1:0] period_q [NUM_CH];
  logic [CNT_WIDTH-1:0] period_d [NUM_CH];
  logic [CNT_WIDTH-1:0] remain_q [NUM_CH];
  logic [CNT_WIDTH-1:0] remain_d [NUM_CH];
  logic [NUM_CH-1:0]    mode_q, mode_d;
  logic [NUM_CH-1:0]    expire_q, expire_d;
  logic [NUM_CH-1:0]    pending_q, pending_d;
  logic [NUM_CH-1:0]    ovr_q, ovr_d;
  logic [NUM_CH-1:0]    evt_clr;
  logic                 evt_valid_q, evt_valid_d;
  logic [CH_W-1:0]      evt_ch_q, evt_ch_d;
  logic                 cfg_ack_q, cfg_err_q;
  logic                 wr_ok;

  assign wr_ok = bus.cfg_we && (32'(bus.cfg_ch) < NUM_CH)
                 && !(bus.cfg_en && (bus.cfg_period == '0));

  // Channel state and counters; an accepted write to a channel masks that cycle's tick.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i]  = state_q[i];
      period_d[i] = period_q[i];
      remain_d[i] = remain_q[i];
      mode_d[i]   = mode_q[i];
      expire_d[i] = 1'b0;
      if (wr_ok && (bus.cfg_ch == CH_W'(i))) begin
        if (bus.cfg_en) begin
          state_d[i]  = StRun;
          period_d[i] = bus.cfg_period;
          remain_d[i] = bus.cfg_period;
          mode_d[i]   = bus.cfg_mode;
        end else begin
          state_d[i] = StIdle;
        end
      end else if ((state_q[i] == StRun) && tick) begin
        if (remain_q[i] > CNT_WIDTH'(1)) begin
          remain_d[i] = remain_q[i] - CNT_WIDTH'(1);
        end else begin
          expire_d[i] = 1'b1;
          if (mode_q[i]) begin
            state_d[i] = StIdle;
          end else begin
            remain_d[i] = period_q[i];
          end
        end
      end
    end
  end

  // Pending set beats an ack-clear of the same bit; any expiry on a pending bit is an overrun.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      evt_clr[i] = bus.evt_ack && evt_valid_q && (evt_ch_q == CH_W'(i));
    end
    pending_d = (pending_q & ~evt_clr) | expire_d;
    ovr_d     = ovr_q | (expire_d & pending_q);
  end

  always_comb begin
    evt_valid_d = |pending_d;
    evt_ch_d    = '0;
    for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
      if (pending_d[i]) begin
        evt_ch_d = CH_W'(i);
      end
    end
  end

  always_ff @(posedge clk_100Mhz or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= StIdle;
        period_q[i] <= '0;
        remain_q[i] <= '0;
      end
      mode_q      <= '0;
      expire_q    <= '0;
      pending_q   <= '0;
      ovr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      cfg_ack_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i]  <= state_d[i];
        period_q[i] <= period_d[i];
        remain_q[i] <= remain_d[i];
      end
      mode_q      <= mode_d;
      expire_q    <= expire_d;
      pending_q   <= pending_d;
      ovr_q       <= ovr_d;
      evt_valid_q <= evt_valid_d;
      evt_ch_q    <= evt_ch_d;
      cfg_ack_q   <= wr_ok;
      cfg_err_q   <= bus.cfg_we && !wr_ok;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_busy[i] = (state_q[i] == StRun);
    end
  end

  assign ch_expire     = expire_q;
  assign evt_ovr       = ovr_q;
  assign bus.evt_valid = evt_valid_q;
  assign bus.evt_ch    = evt_ch_q;
  assign bus.cfg_ack   = cfg_ack_q;
  assign bus.cfg_err   = cfg_err_q;

endmodule
